// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU data-port bus between the multicycle CPU and the data-memory responder.
interface dmem_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [1:0]  size;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;
  modport master (output addr, wdata, we, re, size, input rdata, ready, busy, err);
  modport slave  (input addr, wdata, we, re, size, output rdata, ready, busy, err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word/half/byte data memory with read-modify-write sub-word stores.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses on err instead of ignoring low address bits.
module dmem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_word;
  logic [1:0]  r_size;
  logic        r_wr;
  logic [31:0] r_mem [DEPTH];
  logic        w_acc, w_mis_in, w_mis_r, w_byte, w_sub;
  logic [AW-1:0] w_idx;
  logic [4:0]  w_sh;
  logic [31:0] w_keep, w_merged, w_load;
  function automatic state_t f_tgt(input logic wr, input logic [1:0] sz, input logic mis);
    return mis ? S_DONE : (wr && (sz == 2'd0 || sz == 2'd3)) ? S_WRITE : S_READ;
  endfunction
  assign w_acc = (r_state == S_IDLE) && (bus.we || bus.re);
`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;
  assign w_mis_in = (bus.size == 2'd1) ? bus.addr[0] : (bus.size != 2'd2 && bus.addr[1:0] != 2'b0);
  assign w_mis_r  = r_err;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_err <= 1'b0;
    else if (w_acc) r_err <= w_mis_in;
`else
  assign w_mis_in = 1'b0;
  assign w_mis_r  = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.we || bus.re)
                 w_next = (WAIT_STATES > 0) ? S_WAIT : f_tgt(bus.we, bus.size, w_mis_in);
      S_WAIT:  if (r_cnt == 4'd0) w_next = f_tgt(r_wr, r_size, w_mis_r);
      S_READ:  w_next = r_wr ? S_WRITE : S_DONE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_acc) r_cnt <= 4'(WAIT_STATES - 1);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
    end
  // Out-of-range addresses wrap onto the array rather than being rejected.
  assign w_idx    = AW'((r_addr - BASE_ADDR) >> 2);
  assign w_byte   = r_size == 2'd2;
  assign w_sub    = (r_size == 2'd1) || w_byte;
  assign w_keep   = w_byte ? 32'h0000_00FF : 32'h0000_FFFF;
  assign w_sh     = w_byte ? {r_addr[1:0], 3'b0} : {r_addr[1], 4'b0};
  assign w_merged = w_sub ? (r_word & ~(w_keep << w_sh)) | ((r_wdata & w_keep) << w_sh) : r_wdata;
  assign w_load   = w_sub ? (r_word >> w_sh) & w_keep : r_word;
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
      r_size  <= bus.size;
      r_wr    <= bus.we;
    end
    if (r_state == S_READ) r_word <= r_mem[w_idx];
    if (r_state == S_WRITE) r_mem[w_idx] <= w_merged;
  end
  assign bus.ready = r_state == S_DONE;
  assign bus.busy  = r_state != S_IDLE;
  assign bus.rdata = (r_state == S_DONE && !r_wr && !w_mis_r) ? w_load : 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.err = (r_state == S_DONE) && r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule
